cons_inject_arb: RTL and testbench
==================================

# cons_inject_arb

Console-input scheduler that shares the console receive FIFO write port between the live UART RX path and a command-injection stream fed by the simulation or debug command loader. Injected command lines are buffered internally and released only after boot completes, one byte per free slot, with a programmable gap between bytes. UART bytes always win the shared port. The block sits between the command loader, the UART RX deserializer and the console FIFO, whose read-enable `r_consf_en` it observes as a busy indication.

## Interface
Parameters:
- `DEPTH`, 16: injection buffer entries (power of two, ≥2).
- `GAP`, 4: idle cycles enforced after each injected byte (0 allowed).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `RST_X`  in  1  reset, synchronous, active-low.
- `w_mtime`  in  64  current machine timer.
- `min_time`  in  64  timer value after which boot is considered done.
- `cmd_valid`  in  1  loader byte valid.
- `cmd_data`  in  8  loader byte.
- `cmd_last`  in  1  byte is the final byte of a line.
- `cmd_ready`  out  1  buffer can accept; push occurs on `cmd_valid & cmd_ready`.
- `uart_we`  in  1  UART RX byte strobe, one cycle.
- `uart_data`  in  8  UART RX byte.
- `r_consf_en`  in  1  console FIFO being read; injection is blocked while 1.
- `out_we`  out  1  console FIFO write strobe, one-cycle pulse.
- `out_data`  out  8  console FIFO write data.
- `boot_done`  out  1  sticky boot-complete flag.
- `inj_busy`  out  1  a complete line is pending or being sent.

## Operation
- Boot: `boot_done` is set when `w_mtime >= min_time` (unsigned 64-bit compare) and stays set until reset.
- Buffer: circular, DEPTH entries. Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH. `cmd_ready = !full`. Push and pop in the same cycle are legal; count is unchanged.
- `lines` counter: incremented on a push with `cmd_last`, decremented when a byte flagged last is emitted. Saturates at DEPTH. Push-with-last and pop-of-last in the same cycle leave it unchanged.
- Forced flush: if the buffer is full and `lines == 0`, the current head-to-tail contents are treated as one line. The last stored byte is re-flagged last and `lines` is set to 1, which prevents deadlock.
- FSM states:
  - WAIT_BOOT → IDLE when `boot_done`.
  - IDLE → SEND when `lines > 0`.
  - SEND: a byte is emitted on the first cycle with `!uart_we & !r_consf_en`. Then → GAP if GAP > 0; otherwise stay in SEND, or go to IDLE if the byte was last.
  - GAP: counts GAP cycles, then → SEND if more bytes remain in the line, else → IDLE.
- Arbitration: `uart_we` has absolute priority. Its byte is passed through even in WAIT_BOOT, and an injected byte is deferred in that cycle (the FSM holds SEND). UART bytes do not restart or extend the GAP count.
- `inj_busy = (state != WAIT_BOOT) & (lines > 0 | state != IDLE)`.

## Timing
- Reset values: `out_we=0`, `out_data=0`, `boot_done=0`, `cmd_ready=1`, `inj_busy=0`, FSM=WAIT_BOOT, pointers, `lines` and gap counter all 0. Reset mid-line discards all buffered bytes.
- `out_we`/`out_data` are registered:
  - A UART byte at edge N appears at edge N+1.
  - An injected byte appears one cycle after its SEND-eligible cycle.
- `boot_done` rises one cycle after the compare first holds. The first injected byte can appear no earlier than 3 cycles after that.
- Consecutive injected bytes are spaced exactly GAP+1 cycles apart when the port is uncontended.
- `cmd_ready` is combinational from registered count. It re-asserts the cycle after a pop from full.

## Configuration
- `CONS_INJ_CRLF_EN` defined: each injected byte equal to 8'h0A is emitted as 8'h0D, so a file newline becomes terminal Enter. UART bytes are never altered.
- Not defined: injected bytes are emitted unmodified.

## Test plan
- Boot gating: push line "ls\n" with `min_time=100` and `w_mtime` ramping from 0 → no `out_we` before mtime 100. Then 'l','s',0x0A are emitted GAP+1 cycles apart (0x0D instead of 0x0A with `CONS_INJ_CRLF_EN`).
- UART priority: assert `uart_we` with 0x41 in the cycle an injected 'x' is eligible → `out_data=0x41` at the next edge, 'x' one cycle later, gap unaffected.
- Busy hold: `r_consf_en=1` for 10 cycles with a pending line → no injected `out_we` during those cycles. The first byte follows 1 cycle after `r_consf_en` falls.
- Full/flush: push 16 bytes with no `cmd_last` → `cmd_ready=0`, forced flush emits all 16 in order, `cmd_ready` returns to 1.
- Wrap/simultaneous: stream 40 bytes in 4 lines while draining → pointers wrap, output order equals input order, `lines` returns to 0.
- Reset mid-send: assert `RST_X=0` after 2 of 5 bytes → all outputs at reset values, no residual bytes emitted after release.

Source files
------------

// File: rtl/cons_inject_arb.sv
// cons_inject_arb
//   Shares the console receive FIFO write port between the live UART RX path
//   and a buffered command-injection stream. Injected lines are held until
//   boot completes, then released one byte per free slot, with GAP idle
//   cycles after each byte. UART bytes always win the port.
//
// Ports:
//   clk, RST_X           clock, synchronous active-low reset
//   w_mtime, min_time    boot is done once w_mtime >= min_time (sticky)
//   cmd_valid/data/last  loader byte stream; cmd_ready = buffer not full
//   uart_we, uart_data   UART RX byte strobe (absolute priority)
//   r_consf_en           console FIFO read in progress; blocks injection
//   out_we, out_data     registered console FIFO write port
//   boot_done            sticky boot-complete flag
//   inj_busy             complete line pending or being sent
//
// Build option:
//   CONS_INJ_CRLF_EN     injected 8'h0A bytes are emitted as 8'h0D

module cons_inject_arb #(
   parameter int DEPTH = 16,
   parameter int GAP   = 4
) (
   input  logic        clk,
   input  logic        RST_X,
   input  logic [63:0] w_mtime,
   input  logic [63:0] min_time,
   input  logic        cmd_valid,
   input  logic [7:0]  cmd_data,
   input  logic        cmd_last,
   output logic        cmd_ready,
   input  logic        uart_we,
   input  logic [7:0]  uart_data,
   input  logic        r_consf_en,
   output logic        out_we,
   output logic [7:0]  out_data,
   output logic        boot_done,
   output logic        inj_busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int GW = $clog2(GAP + 2);

   typedef enum logic [1:0] {ST_WAIT_BOOT, ST_IDLE, ST_SEND, ST_GAP} state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         lines_q, lines_d;
   logic [DEPTH-1:0][8:0] mem_q, mem_d;      // {last, data}
   logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
   logic                  last_sent_q, last_sent_d;
   logic                  boot_done_q, boot_done_d;
   logic                  out_we_q, out_we_d;
   logic [7:0]            out_data_q, out_data_d;

   logic [PW-1:0] count, wr_prev;
   logic          full, empty, push, pop, flush;
   logic [8:0]    head;
   logic [7:0]    inj_byte;

   assign count     = wr_ptr_q - rd_ptr_q;
   assign wr_prev   = wr_ptr_q - PW'(1);
   assign full      = (count == PW'(DEPTH));
   assign empty     = (count == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid & !full;
   assign head      = mem_q[rd_ptr_q[AW-1:0]];
   // A full buffer with no line end can never drain on its own: treat the
   // whole contents as one line.
   assign flush     = full & (lines_q == '0);

`ifdef CONS_INJ_CRLF_EN
   assign inj_byte = (head[7:0] == 8'h0A) ? 8'h0D : head[7:0];
`else
   assign inj_byte = head[7:0];
`endif

   // FSM: next state and injection pop
   always_comb begin
      state_d     = state_q;
      gap_cnt_d   = gap_cnt_q;
      last_sent_d = last_sent_q;
      pop         = 1'b0;
      case (state_q)
         ST_WAIT_BOOT: if (boot_done_q) state_d = ST_IDLE;
         ST_IDLE:      if (lines_q != '0) state_d = ST_SEND;
         ST_SEND: begin
            // UART or a FIFO read defers the byte; state holds in SEND.
            if (!uart_we && !r_consf_en && !empty) begin
               pop         = 1'b1;
               last_sent_d = head[8];
               if (GAP > 0) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = '0;
               end else if (head[8]) begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            // UART traffic does not stretch the gap.
            if (gap_cnt_q == GW'(GAP - 1))
               state_d = last_sent_q ? ST_IDLE : ST_SEND;
            else
               gap_cnt_d = gap_cnt_q + GW'(1);
         end
         default: state_d = ST_WAIT_BOOT;
      endcase
   end

   // Buffer, line counter and output port
   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      mem_d    = mem_q;
      if (push)  mem_d[wr_ptr_q[AW-1:0]] = {cmd_last, cmd_data};
      if (flush) mem_d[wr_prev[AW-1:0]][8] = 1'b1;

      lines_d = lines_q;
      if (flush)
         lines_d = PW'(1);
      else if ((push & cmd_last) && !(pop & head[8])) begin
         if (lines_q != PW'(DEPTH)) lines_d = lines_q + PW'(1);
      end else if (!(push & cmd_last) && (pop & head[8]))
         lines_d = lines_q - PW'(1);

      boot_done_d = boot_done_q | (w_mtime >= min_time);
      out_we_d    = uart_we | pop;
      out_data_d  = out_data_q;
      if (uart_we)  out_data_d = uart_data;
      else if (pop) out_data_d = inj_byte;
   end

   always_ff @(posedge clk) begin
      if (!RST_X) begin
         state_q     <= ST_WAIT_BOOT;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         lines_q     <= '0;
         mem_q       <= '0;
         gap_cnt_q   <= '0;
         last_sent_q <= 1'b0;
         boot_done_q <= 1'b0;
         out_we_q    <= 1'b0;
         out_data_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         lines_q     <= lines_d;
         mem_q       <= mem_d;
         gap_cnt_q   <= gap_cnt_d;
         last_sent_q <= last_sent_d;
         boot_done_q <= boot_done_d;
         out_we_q    <= out_we_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_we    = out_we_q;
   assign out_data  = out_data_q;
   assign boot_done = boot_done_q;
   assign inj_busy  = (state_q != ST_WAIT_BOOT) &
                      ((lines_q != '0) | (state_q != ST_IDLE));

endmodule

// File: tb/tb_cons_inject_arb.sv
module tb_cons_inject_arb;
   localparam int DEPTH = 16;
   localparam int GAP   = 4;
`ifdef CONS_INJ_CRLF_EN
   localparam logic [7:0] NL_OUT = 8'h0D;
`else
   localparam logic [7:0] NL_OUT = 8'h0A;
`endif

   logic        clk = 1'b0;
   logic        RST_X;
   logic [63:0] w_mtime = 64'd0;
   logic [63:0] min_time;
   logic        cmd_valid, cmd_last, cmd_ready;
   logic [7:0]  cmd_data;
   logic        uart_we, r_consf_en;
   logic [7:0]  uart_data;
   logic        out_we, boot_done, inj_busy;
   logic [7:0]  out_data;

   cons_inject_arb #(.DEPTH(DEPTH), .GAP(GAP)) dut (
      .clk(clk), .RST_X(RST_X), .w_mtime(w_mtime), .min_time(min_time),
      .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_last(cmd_last),
      .cmd_ready(cmd_ready), .uart_we(uart_we), .uart_data(uart_data),
      .r_consf_en(r_consf_en), .out_we(out_we), .out_data(out_data),
      .boot_done(boot_done), .inj_busy(inj_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) w_mtime <= w_mtime + 64'd1;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          nvec = 0, nerr = 0;
   logic [7:0]  exp_q[$];
   int          outc[$];
   logic [63:0] outmt[$];
   logic [7:0]  mon_e;

   // Scoreboard monitor: every write on the console port must match the
   // next expected byte.
   always @(negedge clk) begin
      if (out_we === 1'b1) begin
         outc.push_back(cyc);
         outmt.push_back(w_mtime);
         nvec++;
         if (exp_q.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_out: got %02h, expected no write (cycle %0d)", out_data, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            if (out_data !== mon_e) begin
               nerr++;
               $display("FAIL out_data: got %02h, expected %02h (cycle %0d)", out_data, mon_e, cyc);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic push_byte(input logic [7:0] d, input logic last);
      int n = 0;
      cmd_valid = 1'b1; cmd_data = d; cmd_last = last;
      while (!cmd_ready && n < 300) begin tick(); n++; end
      if (n >= 300) begin
         nvec++; nerr++;
         $display("FAIL push_timeout: got cmd_ready=0, expected 1 within 300 cycles");
      end
      tick();
      cmd_valid = 1'b0; cmd_last = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin tick(); n++; end
      if (exp_q.size() > 0) begin
         nvec++; nerr++;
         $display("FAIL drain_timeout: got %0d bytes outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic clr_out();
      outc.delete(); outmt.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      int rel, n;
      RST_X = 1'b0; min_time = 64'd100;
      cmd_valid = 1'b0; cmd_data = 8'h00; cmd_last = 1'b0;
      uart_we = 1'b0; uart_data = 8'h00; r_consf_en = 1'b0;
      tick(3);
      chk("rst_out_we", out_we, 1'b0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_boot_done", boot_done, 1'b0);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_inj_busy", inj_busy, 1'b0);
      RST_X = 1'b1;
      tick();

      // Boot gating: "ls\n" held until mtime reaches 100
      clr_out();
      push_byte("l", 1'b0); push_byte("s", 1'b0); push_byte(8'h0A, 1'b1);
      exp_q.push_back("l"); exp_q.push_back("s"); exp_q.push_back(NL_OUT);
      n = 0;
      while (w_mtime < 64'd60 && n < 200) begin tick(); n++; end
      chk("preboot_boot_done", boot_done, 1'b0);
      chk("preboot_inj_busy", inj_busy, 1'b0);
      chk("preboot_out_count", outc.size(), 0);
      drain(300);
      tick(10);
      chk("boot_out_count", outc.size(), 3);
      if (outc.size() == 3) begin
         chk("boot_first_after_mtime", outmt[0] >= 64'd104, 1'b1);
         chk("boot_gap1", outc[1] - outc[0], GAP + 1);
         chk("boot_gap2", outc[2] - outc[1], GAP + 1);
      end
      chk("boot_done_set", boot_done, 1'b1);
      chk("boot_idle_busy", inj_busy, 1'b0);
      min_time = '1;
      tick(2);
      chk("boot_done_sticky", boot_done, 1'b1);
      min_time = 64'd100;

      // UART priority: 0x41 collides with the first eligible cycle of 'x'
      clr_out();
      exp_q.push_back(8'h41); exp_q.push_back("x"); exp_q.push_back("y");
      push_byte("x", 1'b0); push_byte("y", 1'b1);
      tick();
      uart_we = 1'b1; uart_data = 8'h41;
      tick();
      uart_we = 1'b0;
      drain(100);
      tick(10);
      chk("prio_out_count", outc.size(), 3);
      if (outc.size() == 3) begin
         chk("prio_defer", outc[1] - outc[0], 1);
         chk("prio_gap", outc[2] - outc[1], GAP + 1);
      end

      // Busy hold: FIFO read in progress blocks injection
      clr_out();
      r_consf_en = 1'b1;
      push_byte("a", 1'b0); push_byte("b", 1'b0); push_byte(8'h0A, 1'b1);
      exp_q.push_back("a"); exp_q.push_back("b"); exp_q.push_back(NL_OUT);
      tick(10);
      chk("hold_out_count", outc.size(), 0);
      chk("hold_inj_busy", inj_busy, 1'b1);
      r_consf_en = 1'b0;
      rel = cyc;
      drain(100);
      tick(10);
      chk("hold_out_total", outc.size(), 3);
      if (outc.size() > 0) chk("hold_release_lat", outc[0], rel + 1);

      // Full buffer, no line end: forced flush
      clr_out();
      for (int i = 0; i < DEPTH; i++) begin
         push_byte(8'h10 + 8'(i), 1'b0);
         exp_q.push_back(8'h10 + 8'(i));
      end
      chk("full_cmd_ready", cmd_ready, 1'b0);
      drain(300);
      tick(10);
      chk("flush_out_count", outc.size(), DEPTH);
      chk("flush_cmd_ready", cmd_ready, 1'b1);
      chk("flush_inj_busy", inj_busy, 1'b0);

      // Wrap: 40 bytes in 4 lines while draining
      clr_out();
      for (int i = 0; i < 40; i++) exp_q.push_back(8'h80 + 8'(i));
      for (int i = 0; i < 40; i++) push_byte(8'h80 + 8'(i), (i % 10) == 9);
      drain(1000);
      tick(10);
      chk("wrap_out_count", outc.size(), 40);
      chk("wrap_inj_busy", inj_busy, 1'b0);
      chk("wrap_cmd_ready", cmd_ready, 1'b1);

      // Reset after 2 of 5 bytes
      clr_out();
      for (int i = 0; i < 5; i++) exp_q.push_back("1" + 8'(i));
      for (int i = 0; i < 5; i++) push_byte("1" + 8'(i), i == 4);
      n = 0;
      while (outc.size() < 2 && n < 200) begin tick(); n++; end
      chk("rst_mid_seen2", outc.size(), 2);
      RST_X = 1'b0;
      exp_q.delete();
      tick(2);
      chk("rst_mid_out_we", out_we, 1'b0);
      chk("rst_mid_out_data", out_data, 8'h00);
      chk("rst_mid_boot_done", boot_done, 1'b0);
      chk("rst_mid_cmd_ready", cmd_ready, 1'b1);
      chk("rst_mid_inj_busy", inj_busy, 1'b0);
      RST_X = 1'b1;
      tick(40);
      chk("rst_mid_no_residual", outc.size(), 2);
      chk("rst_mid_reboot", boot_done, 1'b1);
      chk("rst_mid_idle_busy", inj_busy, 1'b0);

      if (exp_q.size() != 0) begin
         nvec++; nerr++;
         $display("FAIL leftover: got %0d expected bytes pending, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
